bus_synchro_arbiter: RTL

BUS_SYNCHRO_ARBITER -- requirements
Module: bus_synchro_arbiter

---
 rtl/bus_synchro_arbiter_if.sv | 30 +++
 rtl/bus_synchro_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/bus_synchro_arbiter_if.sv
// Requester bus plus synchronizer source-side handshake, grouped for the arbiter.
// master = arbiter side, slave = requesters/synchronizer side.
interface bus_synchro_arbiter_if #(
    parameter int NB_REQ    = 4,
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    localparam int GW = $clog2(NB_REQ);

    logic [NB_REQ-1:0]           req_enable;
    logic [NB_REQ-1:0]           req_tvalid;
    logic [NB_REQ-1:0]           req_tready;
    logic [NB_REQ*BUS_WIDTH-1:0] req_tdata;
    logic                        syn_tvalid;
    logic                        syn_tready;
    logic [BUS_WIDTH-1:0]        syn_tdata;
    logic [GW-1:0]               grant_id;
    logic                        busy;
    logic [CNT_WIDTH-1:0]        xfer_cnt;

    modport master (
        input  req_enable, req_tvalid, req_tdata, syn_tready,
        output req_tready, syn_tvalid, syn_tdata, grant_id, busy, xfer_cnt
    );

    modport slave (
        output req_enable, req_tvalid, req_tdata, syn_tready,
        input  req_tready, syn_tvalid, syn_tdata, grant_id, busy, xfer_cnt
    );
endinterface

// File: rtl/bus_synchro_arbiter.sv
// Round-robin arbiter feeding one CDC synchronizer: grant in IDLE (tready same cycle), data registered, 1 cycle to syn_tvalid.
// Backpressure: SEND holds syn_tdata/grant_id until syn_tready; all requesters stalled meanwhile.
module bus_synchro_arbiter #(
    parameter int NB_REQ    = 4,
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  srst,
    bus_synchro_arbiter_if.master bus
);
    localparam int GW = $clog2(NB_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [GW-1:0]        r_last_grant;
    logic [GW-1:0]        r_grant_id;
    logic [BUS_WIDTH-1:0] r_syn_tdata;
    logic [CNT_WIDTH-1:0] r_xfer_cnt;

    logic [NB_REQ-1:0]    w_elig;
    logic [NB_REQ-1:0]    w_tready;
    logic [GW-1:0]        w_winner;
    logic [GW-1:0]        w_idx;
    logic [BUS_WIDTH-1:0] w_win_data;
    logic                 w_found;
    logic                 w_take;
    logic                 w_done;
    int                   w_sum;

    assign w_elig = bus.req_tvalid & bus.req_enable;

    // Search starts one past the last grant and wraps, so the last winner has lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = 0;
        w_idx    = '0;
        for (int k = 1; k <= NB_REQ; k++) begin
            w_sum = int'(r_last_grant) + k;
            w_idx = GW'(w_sum % NB_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (w_winner == GW'(i)) begin
                w_win_data = bus.req_tdata[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tready     = '0;
        w_take       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && !srst) begin
                    w_tready[w_winner] = 1'b1;
                    w_take             = 1'b1;
                    w_next_state       = SEND;
                end
            end
            SEND: begin
                if (bus.syn_tready) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Reset parks last_grant on the top index so requester 0 wins first.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_syn_tdata  <= '0;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NB_REQ - 1);
            r_xfer_cnt   <= '0;
        end else begin
            if (w_take) begin
                r_syn_tdata  <= w_win_data;
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end
            if (w_done) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.req_tready = w_tready;
    assign bus.syn_tvalid = (r_state == SEND);
    assign bus.busy       = (r_state == SEND) && !srst;
    assign bus.syn_tdata  = r_syn_tdata;
    assign bus.grant_id   = r_grant_id;
    assign bus.xfer_cnt   = r_xfer_cnt;
endmodule
